// File: rtl/osd_ctm_trace_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : osd_ctm_trace_arbiter
//  Purpose  : Merges NUM_PORTS CPU trace-exec streams onto one CTM trace
//             input. Each source has a small FIFO. A round-robin scheduler
//             forwards at most one event per cycle. Events that arrive while
//             their FIFO is full are dropped and counted. The next event
//             forwarded from that port carries an overflow flag and the count.
//  Ports    : clk, rst (async, active-low)
//             enable/in_valid/in_jal/in_jalr   : per-port bit vectors
//             in_pc/in_npc                     : per-port packed ADDR_WIDTH slices
//             trace_valid/pc/npc/jal/jalr      : registered event to the CTM
//             trace_src                        : index of the originating port
//             trace_ovf/trace_drops            : loss report for trace_src
//  Revision : 1.0 - initial release
// ============================================================================
module osd_ctm_trace_arbiter #(
    parameter int  NUM_PORTS  = 4,
    parameter int  ADDR_WIDTH = 32,
    parameter int  FIFO_DEPTH = 2,
    parameter int  CNT_WIDTH  = 8,
    localparam int SRC_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            enable,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] in_pc,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] in_npc,
    input  logic [NUM_PORTS-1:0]            in_jal,
    input  logic [NUM_PORTS-1:0]            in_jalr,
    output logic                            trace_valid,
    output logic [ADDR_WIDTH-1:0]           trace_pc,
    output logic [ADDR_WIDTH-1:0]           trace_npc,
    output logic                            trace_jal,
    output logic                            trace_jalr,
    output logic [SRC_WIDTH-1:0]            trace_src,
    output logic                            trace_ovf,
    output logic [CNT_WIDTH-1:0]            trace_drops
);

    localparam int                       c_PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int                       c_FILL_WIDTH = c_PTR_WIDTH + 1;
    localparam int                       c_PAY_WIDTH  = 2 * ADDR_WIDTH + 2;
    localparam logic [c_FILL_WIDTH-1:0]  c_DEPTH      = c_FILL_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]     c_DROP_MAX   = '1;
    localparam logic [SRC_WIDTH-1:0]     c_LAST_PORT  = SRC_WIDTH'(NUM_PORTS - 1);

    // Per-port FIFO state. Payload layout: {pc, npc, jal, jalr}.
    logic [c_PAY_WIDTH-1:0]  r_mem      [NUM_PORTS][FIFO_DEPTH];
    logic [c_PTR_WIDTH-1:0]  r_wr_ptr   [NUM_PORTS];
    logic [c_PTR_WIDTH-1:0]  r_rd_ptr   [NUM_PORTS];
    logic [c_FILL_WIDTH-1:0] r_fill     [NUM_PORTS];
    logic [CNT_WIDTH-1:0]    r_drop_cnt [NUM_PORTS];
    logic [NUM_PORTS-1:0]    r_ovf_pending;
    logic [SRC_WIDTH-1:0]    r_last_grant;

    logic [NUM_PORTS-1:0]    w_nonempty;
    logic [NUM_PORTS-1:0]    w_pop;
    logic [NUM_PORTS-1:0]    w_push;
    logic [NUM_PORTS-1:0]    w_drop;
    logic                    w_grant;
    logic [SRC_WIDTH-1:0]    w_grant_idx;
    logic [c_PAY_WIDTH-1:0]  w_head;

    // Port index 'off' positions after 'base', wrapping at NUM_PORTS.
    function automatic logic [SRC_WIDTH-1:0] rr_index(input logic [SRC_WIDTH-1:0] base,
                                                      input int off);
        int sum;
        sum = (int'(base) + off) % NUM_PORTS;
        return SRC_WIDTH'(sum);
    endfunction

    always_comb begin
        w_nonempty = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_nonempty[i] = (r_fill[i] != '0);
        end
    end

    // Round-robin search starting one past the last granted port; the last
    // granted port is visited last (off = NUM_PORTS).
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            if (!w_grant && w_nonempty[rr_index(r_last_grant, off)]) begin
                w_grant     = 1'b1;
                w_grant_idx = rr_index(r_last_grant, off);
            end
        end
    end

    // A full FIFO still accepts a new event in the cycle its head is popped,
    // so a drop and a pop can never coincide on the same port.
    always_comb begin
        w_pop  = '0;
        w_push = '0;
        w_drop = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_pop[i]  = w_grant && (w_grant_idx == SRC_WIDTH'(i));
            w_push[i] = in_valid[i] && enable[i] && ((r_fill[i] < c_DEPTH) || w_pop[i]);
            w_drop[i] = in_valid[i] && enable[i] && !w_push[i];
        end
    end

    assign w_head = r_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];

    // Storage needs no reset: fill counts gate every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= {in_pc[i*ADDR_WIDTH +: ADDR_WIDTH],
                                          in_npc[i*ADDR_WIDTH +: ADDR_WIDTH],
                                          in_jal[i], in_jalr[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_wr_ptr[i]   <= '0;
                r_rd_ptr[i]   <= '0;
                r_fill[i]     <= '0;
                r_drop_cnt[i] <= '0;
            end
            r_ovf_pending <= '0;
            r_last_grant  <= c_LAST_PORT;
            trace_valid   <= 1'b0;
            trace_pc      <= '0;
            trace_npc     <= '0;
            trace_jal     <= 1'b0;
            trace_jalr    <= 1'b0;
            trace_src     <= '0;
            trace_ovf     <= 1'b0;
            trace_drops   <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + c_PTR_WIDTH'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + c_PTR_WIDTH'(1);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_fill[i] <= r_fill[i] + c_FILL_WIDTH'(1);
                    2'b01:   r_fill[i] <= r_fill[i] - c_FILL_WIDTH'(1);
                    default: r_fill[i] <= r_fill[i];
                endcase

                // Reporting the loss consumes the count; a drop in that same
                // cycle starts a fresh count of one.
                if (w_pop[i] && r_ovf_pending[i]) begin
                    r_drop_cnt[i]    <= w_drop[i] ? CNT_WIDTH'(1) : '0;
                    r_ovf_pending[i] <= w_drop[i];
                end else if (w_drop[i]) begin
                    if (r_drop_cnt[i] != c_DROP_MAX) begin
                        r_drop_cnt[i] <= r_drop_cnt[i] + CNT_WIDTH'(1);
                    end
                    r_ovf_pending[i] <= 1'b1;
                end
            end

            trace_valid <= w_grant;
            if (w_grant) begin
                r_last_grant <= w_grant_idx;
                {trace_pc, trace_npc, trace_jal, trace_jalr} <= w_head;
                trace_src   <= w_grant_idx;
                trace_ovf   <= r_ovf_pending[w_grant_idx];
                trace_drops <= r_ovf_pending[w_grant_idx] ? r_drop_cnt[w_grant_idx] : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_osd_ctm_trace_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_osd_ctm_trace_arbiter
//  Purpose  : Scoreboard bench for osd_ctm_trace_arbiter. u_dut uses the
//             default 4-port configuration. u_sat uses 8 ports and a 2-bit
//             drop counter so more than three drops can pile up on one port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_osd_ctm_trace_arbiter;

    typedef struct packed {
        logic [2:0]  src;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        jal;
        logic        jalr;
        logic        ovf;
        logic [7:0]  drops;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Four-port DUT
    logic [3:0]   enable, in_valid, in_jal, in_jalr;
    logic [127:0] in_pc, in_npc;
    logic         trace_valid, trace_jal, trace_jalr, trace_ovf;
    logic [31:0]  trace_pc, trace_npc;
    logic [1:0]   trace_src;
    logic [7:0]   trace_drops;

    // Eight-port DUT with a 2-bit drop counter
    logic [7:0]   en2, iv2, jal2, jalr2;
    logic [255:0] pc2, npc2;
    logic         tv2, tjal2, tjalr2, tovf2;
    logic [31:0]  tpc2, tnpc2;
    logic [2:0]   tsrc2;
    logic [1:0]   tdrops2;

    osd_ctm_trace_arbiter u_dut (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
        .in_pc(in_pc), .in_npc(in_npc), .in_jal(in_jal), .in_jalr(in_jalr),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_npc(trace_npc),
        .trace_jal(trace_jal), .trace_jalr(trace_jalr), .trace_src(trace_src),
        .trace_ovf(trace_ovf), .trace_drops(trace_drops)
    );

    osd_ctm_trace_arbiter #(.NUM_PORTS(8), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .enable(en2), .in_valid(iv2),
        .in_pc(pc2), .in_npc(npc2), .in_jal(jal2), .in_jalr(jalr2),
        .trace_valid(tv2), .trace_pc(tpc2), .trace_npc(tnpc2),
        .trace_jal(tjal2), .trace_jalr(tjalr2), .trace_src(tsrc2),
        .trace_ovf(tovf2), .trace_drops(tdrops2)
    );

    ev_t exp_q[$];
    ev_t exp_q2[$];
    int  n_vec  = 0;
    int  n_fail = 0;

    task automatic report(input string tag, input ev_t g, input ev_t e);
        $display("FAIL %s: got src=%0d pc=%h npc=%h jal=%b jalr=%b ovf=%b drops=%0d, expected src=%0d pc=%h npc=%h jal=%b jalr=%b ovf=%b drops=%0d",
                 tag, g.src, g.pc, g.npc, g.jal, g.jalr, g.ovf, g.drops,
                 e.src, e.pc, e.npc, e.jal, e.jalr, e.ovf, e.drops);
    endtask

    // Monitors: pop one expectation per emitted event.
    always @(negedge clk) begin
        ev_t g;
        ev_t e;
        if (rst === 1'b1 && trace_valid === 1'b1) begin
            g = '{src: {1'b0, trace_src}, pc: trace_pc, npc: trace_npc, jal: trace_jal,
                  jalr: trace_jalr, ovf: trace_ovf, drops: trace_drops};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL dut4_unexpected_event: got src=%0d pc=%h, expected no event",
                         g.src, g.pc);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    report("dut4_event", g, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        ev_t g;
        ev_t e;
        if (rst === 1'b1 && tv2 === 1'b1) begin
            g = '{src: tsrc2, pc: tpc2, npc: tnpc2, jal: tjal2, jalr: tjalr2,
                  ovf: tovf2, drops: {6'b0, tdrops2}};
            n_vec++;
            if (exp_q2.size() == 0) begin
                n_fail++;
                $display("FAIL dut8_unexpected_event: got src=%0d pc=%h, expected no event",
                         g.src, g.pc);
            end else begin
                e = exp_q2.pop_front();
                if (g !== e) begin
                    n_fail++;
                    report("dut8_event", g, e);
                end
            end
        end
    end

    task automatic check_zero(input string name, input logic [63:0] act);
        n_vec++;
        if (act !== 64'd0) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected 0", name, act);
        end
    endtask

    task automatic check_idle(input string tag);
        check_zero({tag, "_valid"}, {63'd0, trace_valid});
        check_zero({tag, "_pc"},    {32'd0, trace_pc});
        check_zero({tag, "_npc"},   {32'd0, trace_npc});
        check_zero({tag, "_jal"},   {63'd0, trace_jal});
        check_zero({tag, "_jalr"},  {63'd0, trace_jalr});
        check_zero({tag, "_src"},   {62'd0, trace_src});
        check_zero({tag, "_ovf"},   {63'd0, trace_ovf});
        check_zero({tag, "_drops"}, {56'd0, trace_drops});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid = '0;
        iv2      = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_ev(input int p, input logic [31:0] pc, input logic jal, input logic jalr);
        in_valid[p]         = 1'b1;
        in_pc[p*32 +: 32]   = pc;
        in_npc[p*32 +: 32]  = pc + 32'd4;
        in_jal[p]           = jal;
        in_jalr[p]          = jalr;
    endtask

    task automatic set_ev2(input int p, input logic [31:0] pc);
        iv2[p]            = 1'b1;
        pc2[p*32 +: 32]   = pc;
        npc2[p*32 +: 32]  = pc + 32'd4;
        jal2[p]           = 1'b0;
        jalr2[p]          = 1'b0;
    endtask

    task automatic exp_ev(input int src, input logic [31:0] pc, input logic jal,
                          input logic jalr, input logic ovf, input logic [7:0] drops);
        exp_q.push_back('{src: 3'(src), pc: pc, npc: pc + 32'd4, jal: jal, jalr: jalr,
                          ovf: ovf, drops: drops});
    endtask

    task automatic exp_ev2(input int src, input logic [31:0] pc, input logic ovf,
                           input logic [7:0] drops);
        exp_q2.push_back('{src: 3'(src), pc: pc, npc: pc + 32'd4, jal: 1'b0, jalr: 1'b0,
                           ovf: ovf, drops: drops});
    endtask

    initial begin
        logic [31:0] pcv;
        rst = 1'b0;
        enable = '0; in_valid = '0; in_jal = '0; in_jalr = '0; in_pc = '0; in_npc = '0;
        en2 = '0; iv2 = '0; jal2 = '0; jalr2 = '0; pc2 = '0; npc2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("por");
        rst = 1'b1;

        // Round-robin burst twice; port 0 has priority from reset.
        enable = 4'hF;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 4; p++) begin
                pcv = 32'h10 * (p + 1) + 32'h40 * r;
                set_ev(p, pcv, p[0], p[1]);
                exp_ev(p, pcv, p[0], p[1], 1'b0, 8'd0);
            end
            tick();
            idle(6);
        end

        // Single event on port 0.
        enable = 4'b0001;
        set_ev(0, 32'h100, 1'b1, 1'b0);
        exp_ev(0, 32'h100, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        idle(4);

        // Ports 0 and 1 both stream for 6 cycles; both FIFOs overflow.
        enable = 4'hF;
        exp_ev(1, 32'hB01, 1'b0, 1'b1, 1'b0, 8'd0);
        exp_ev(0, 32'hA01, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_ev(1, 32'hB02, 1'b0, 1'b1, 1'b0, 8'd0);
        exp_ev(0, 32'hA02, 1'b0, 1'b0, 1'b1, 8'd1);
        exp_ev(1, 32'hB03, 1'b0, 1'b1, 1'b1, 8'd1);
        exp_ev(0, 32'hA03, 1'b0, 1'b0, 1'b1, 8'd1);
        exp_ev(1, 32'hB04, 1'b0, 1'b1, 1'b0, 8'd0);
        exp_ev(0, 32'hA05, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_ev(1, 32'hB06, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            set_ev(0, 32'hA00 + k, 1'b0, 1'b0);
            set_ev(1, 32'hB00 + k, 1'b0, 1'b1);
            tick();
        end
        idle(6);

        // Port 3 disabled: toggling valid produces nothing.
        enable = 4'b0111;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) set_ev(3, 32'h333, 1'b0, 1'b0);
            tick();
        end

        // Queue two on port 3, then disable it: both still drain.
        enable = 4'hF;
        set_ev(0, 32'hF00, 1'b0, 1'b0);
        set_ev(1, 32'hF10, 1'b0, 1'b0);
        set_ev(2, 32'hF20, 1'b0, 1'b0);
        set_ev(3, 32'hE01, 1'b1, 1'b1);
        exp_ev(2, 32'hF20, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_ev(3, 32'hE01, 1'b1, 1'b1, 1'b0, 8'd0);
        exp_ev(0, 32'hF00, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_ev(1, 32'hF10, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_ev(3, 32'hE02, 1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        set_ev(3, 32'hE02, 1'b1, 1'b1);
        tick();
        enable = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            set_ev(3, 32'hEEE, 1'b0, 1'b0);
            tick();
        end
        enable = 4'hF;
        idle(3);

        // Fill FIFOs, then reset asynchronously between edges.
        for (int p = 0; p < 4; p++) set_ev(p, 32'hD00 + 32'(p), 1'b0, 1'b0);
        tick();
        for (int p = 0; p < 4; p++) set_ev(p, 32'hD10 + 32'(p), 1'b0, 1'b0);
        exp_ev(0, 32'hD00, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check_idle("async_rst");
        @(posedge clk);
        #2 rst = 1'b1;
        idle(5);
        for (int p = 0; p < 4; p++) begin
            set_ev(p, 32'hC00 + 32'(p), 1'b1, 1'b0);
            exp_ev(p, 32'hC00 + 32'(p), 1'b1, 1'b0, 1'b0, 8'd0);
        end
        tick();
        idle(6);

        // Saturation on the 8-port instance: five drops on port 2.
        en2 = 8'hFF;
        for (int p = 0; p < 8; p++) begin
            if (p != 2) begin
                set_ev2(p, 32'h2000 + 32'(p * 16));
                exp_ev2(p, 32'h2000 + 32'(p * 16), 1'b0, 8'd0);
            end
        end
        exp_ev2(0, 32'h2100, 1'b0, 8'd0);
        exp_ev2(1, 32'h2110, 1'b0, 8'd0);
        exp_ev2(2, 32'h3001, 1'b1, 8'd3);
        exp_ev2(2, 32'h3002, 1'b0, 8'd0);
        tick();
        idle(2);
        for (int k = 1; k <= 7; k++) begin
            set_ev2(2, 32'h3000 + 32'(k));
            if (k == 4) begin
                set_ev2(0, 32'h2100);
                set_ev2(1, 32'h2110);
            end
            tick();
        end
        idle(6);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL dut4_drain: got %0d events outstanding, expected 0", exp_q.size());
        end
        n_vec++;
        if (exp_q2.size() != 0) begin
            n_fail++;
            $display("FAIL dut8_drain: got %0d events outstanding, expected 0", exp_q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
